// File: rtl/keypad_pkg.sv
// Shared definitions for the 3x4 membrane keypad emulator: key codes,
// row/column encodings, FSM states and the key-code to matrix position map.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        ROW_B = 2'd0,
        ROW_G = 2'd1,
        ROW_F = 2'd2,
        ROW_D = 2'd3
    } row_e;

    typedef enum logic [1:0] {
        COL_C = 2'd0,
        COL_A = 2'd1,
        COL_E = 2'd2
    } col_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BOUNCE_IN  = 2'd1,
        ST_HOLD       = 2'd2,
        ST_BOUNCE_OUT = 2'd3
    } state_e;

    typedef enum logic {
        PH_IN  = 1'b0,
        PH_OUT = 1'b1
    } phase_e;

    typedef struct packed {
        logic valid;
        row_e row;
        col_e col;
    } key_loc_t;

    // Matrix position of a key; valid=0 for codes outside the 12-key set.
    function automatic key_loc_t key_to_rowcol(input logic [3:0] code);
        key_loc_t loc;
        loc.valid = 1'b1;
        loc.row   = ROW_B;
        loc.col   = COL_C;
        case (code)
            4'h1:     begin loc.row = ROW_B; loc.col = COL_C; end
            4'h2:     begin loc.row = ROW_B; loc.col = COL_A; end
            4'h3:     begin loc.row = ROW_B; loc.col = COL_E; end
            4'h4:     begin loc.row = ROW_G; loc.col = COL_C; end
            4'h5:     begin loc.row = ROW_G; loc.col = COL_A; end
            4'h6:     begin loc.row = ROW_G; loc.col = COL_E; end
            4'h7:     begin loc.row = ROW_F; loc.col = COL_C; end
            4'h8:     begin loc.row = ROW_F; loc.col = COL_A; end
            4'h9:     begin loc.row = ROW_F; loc.col = COL_E; end
            KEY_STAR: begin loc.row = ROW_D; loc.col = COL_C; end
            4'h0:     begin loc.row = ROW_D; loc.col = COL_A; end
            KEY_HASH: begin loc.row = ROW_D; loc.col = COL_E; end
            default:  loc.valid = 1'b0;
        endcase
        return loc;
    endfunction

endpackage

// File: rtl/kp_bounce_gen.sv
// Segment timer for one contact-bounce phase: counts cycles per segment and
// segments per phase, and predicts the contact level for the next cycle.
module kp_bounce_gen
    import keypad_pkg::*;
#(
    parameter int unsigned BOUNCE_PERIOD  = 3,
    parameter int unsigned BOUNCE_TOGGLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic run_i,
    input  logic phase_i,
    output logic phase_end_c_o,
    output logic next_lvl_c_o
);

    localparam int unsigned CNT_W = $clog2(BOUNCE_PERIOD) + 1;
    localparam int unsigned SEG_W = $clog2(BOUNCE_TOGGLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             seg_end_c;
    logic             next_odd_c;

    // Even segments close the contact on the way in and open it on the way out.
    always_comb begin
        seg_end_c     = (cnt_q == CNT_W'(BOUNCE_PERIOD - 1));
        phase_end_c_o = seg_end_c && (seg_q == SEG_W'(BOUNCE_TOGGLES - 1));
        next_odd_c    = seg_end_c ? ~seg_q[0] : seg_q[0];
        next_lvl_c_o  = (phase_i == PH_OUT) ? next_odd_c : ~next_odd_c;

        cnt_d = cnt_q;
        seg_d = seg_q;
        if (start_i) begin
            cnt_d = '0;
            seg_d = '0;
        end else if (run_i) begin
            if (seg_end_c) begin
                cnt_d = '0;
                seg_d = seg_q + SEG_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            seg_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            seg_q <= seg_d;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Far-end model of a 3x4 membrane keypad: presses one requested key with
// press/release bounce and returns row strobes on the matching column line.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 200,
    parameter int unsigned BOUNCE_PERIOD  = 3,
    parameter int unsigned BOUNCE_TOGGLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       B,
    input  logic       G,
    input  logic       F,
    input  logic       D,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY_CODE,
    output logic       A,
    output logic       C,
    output logic       E,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int unsigned HOLD_W    = $clog2(HOLD_CYCLES) + 1;
    localparam bit          NO_BOUNCE = (BOUNCE_TOGGLES == 0);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              contact_q, contact_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    row_e              row_q, row_d;
    col_e              col_q, col_d;

    key_loc_t          req_loc_c;
    logic              accept_c;
    logic              hold_end_c;
    logic              phase_end_c;
    logic              next_lvl_c;
    logic              row_hit_c;

    always_comb begin
        req_loc_c  = key_to_rowcol(KEY_CODE);
        accept_c   = (state_q == ST_IDLE) && KEY_VALID && req_loc_c.valid;
        hold_end_c = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
    end

    kp_bounce_gen #(
        .BOUNCE_PERIOD (BOUNCE_PERIOD),
        .BOUNCE_TOGGLES(BOUNCE_TOGGLES)
    ) u_bounce (
        .clk_i        (CLK),
        .rst_i        (RST),
        .start_i      (state_d != state_q),
        .run_i        ((state_q == ST_BOUNCE_IN) || (state_q == ST_BOUNCE_OUT)),
        .phase_i      (state_q == ST_BOUNCE_OUT),
        .phase_end_c_o(phase_end_c),
        .next_lvl_c_o (next_lvl_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = NO_BOUNCE ? ST_HOLD : ST_BOUNCE_IN;
            end
            ST_BOUNCE_IN: begin
                if (phase_end_c) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_end_c) state_d = NO_BOUNCE ? ST_IDLE : ST_BOUNCE_OUT;
            end
            ST_BOUNCE_OUT: begin
                if (phase_end_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the contact, pulse outputs, key latches and hold timer.
    always_comb begin
        contact_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        row_d     = row_q;
        col_d     = col_q;
        hold_d    = '0;
        case (state_q)
            ST_IDLE: begin
                err_d = KEY_VALID && !req_loc_c.valid;
                if (accept_c) begin
                    contact_d = 1'b1;
                    row_d     = req_loc_c.row;
                    col_d     = req_loc_c.col;
                end
            end
            ST_BOUNCE_IN: begin
                contact_d = phase_end_c ? 1'b1 : next_lvl_c;
            end
            ST_HOLD: begin
                contact_d = !hold_end_c;
                done_d    = hold_end_c && NO_BOUNCE;
                if (!hold_end_c) hold_d = hold_q + HOLD_W'(1);
            end
            ST_BOUNCE_OUT: begin
                contact_d = phase_end_c ? 1'b0 : next_lvl_c;
                done_d    = phase_end_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q    <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            row_q     <= ROW_B;
            col_q     <= COL_C;
        end else begin
            hold_q    <= hold_d;
            contact_q <= contact_d;
            done_q    <= done_d;
            err_q     <= err_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

    // Passive matrix path: no register between strobe and column return.
    always_comb begin
        row_hit_c = 1'b0;
        case (row_q)
            ROW_B:   row_hit_c = B;
            ROW_G:   row_hit_c = G;
            ROW_F:   row_hit_c = F;
            ROW_D:   row_hit_c = D;
            default: row_hit_c = 1'b0;
        endcase
        A = contact_q && row_hit_c && (col_q == COL_A);
        C = contact_q && row_hit_c && (col_q == COL_C);
        E = contact_q && row_hit_c && (col_q == COL_E);
    end

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = done_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: table of key presses with a
// done-time scoreboard, plus reset-mid-press and no-bounce sequences.
module tb_keypad_emulator;

    localparam int H_DEF  = 200;
    localparam int P_DEF  = 3;
    localparam int T_DEF  = 4;
    localparam int PRESS  = 2 * T_DEF * P_DEF + H_DEF;
    localparam int H_NB   = 10;

    typedef struct {
        logic [3:0] code;
        logic [3:0] strb;    // {B,G,F,D}
        logic [2:0] cols;    // {C,A,E} while contact is closed
        bit         is_err;
        int         inject_t;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       b, g, f, d, kv;
    logic [3:0] kc;
    logic       a, c, e, busy, done, err;
    logic       b2, g2, f2, d2, kv2;
    logic [3:0] kc2;
    logic       a2, c2, e2, busy2, done2, err2;

    int total = 0;
    int bad   = 0;
    int sb_q[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    keypad_emulator u_dut (
        .CLK(clk), .RST(rst), .B(b), .G(g), .F(f), .D(d),
        .KEY_VALID(kv), .KEY_CODE(kc),
        .A(a), .C(c), .E(e), .BUSY(busy), .DONE(done), .ERR(err)
    );

    keypad_emulator #(
        .HOLD_CYCLES(H_NB), .BOUNCE_PERIOD(3), .BOUNCE_TOGGLES(0)
    ) u_dut_nb (
        .CLK(clk), .RST(rst), .B(b2), .G(g2), .F(f2), .D(d2),
        .KEY_VALID(kv2), .KEY_CODE(kc2),
        .A(a2), .C(c2), .E(e2), .BUSY(busy2), .DONE(done2), .ERR(err2)
    );

    function automatic bit exp_contact(input int t, input int tg, input int p, input int h);
        int bt;
        bt = tg * p;
        if (t < bt)          return ((t / p) % 2) == 0;
        if (t < bt + h)      return 1'b1;
        if (t < 2 * bt + h)  return ((((t - bt - h) / p) % 2) == 1);
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input vec_t v, input string tag);
        int   t, busy_n, col_bad, err_n;
        bit   got;
        logic [2:0] expc;
        {b, g, f, d} = v.strb;
        kc = v.code;
        kv = 1'b1;
        tick();
        kv = 1'b0;
        if (v.is_err) begin
            check({tag, "_err"}, int'(err), 1);
            check({tag, "_busy"}, int'(busy), 0);
            check({tag, "_cols"}, int'({c, a, e}), 0);
            tick();
            check({tag, "_err_off"}, int'(err), 0);
            check({tag, "_busy_off"}, int'(busy), 0);
            return;
        end
        sb_q.push_back(PRESS);
        busy_n = 0; col_bad = 0; err_n = 0; got = 1'b0; t = 0;
        while (!got && t <= PRESS + 8) begin
            if (t == v.inject_t) begin
                kc = 4'h1;
                kv = 1'b1;
            end
            expc = exp_contact(t, T_DEF, P_DEF, H_DEF) ? v.cols : 3'b000;
            if ({c, a, e} != expc) col_bad++;
            if (busy) busy_n++;
            if (err) err_n++;
            if (done) begin
                got = 1'b1;
                if (sb_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
                else check({tag, "_done_t"}, t, sb_q.pop_front());
            end else begin
                tick();
                kv = 1'b0;
                t++;
            end
        end
        check({tag, "_done_seen"}, int'(got), 1);
        check({tag, "_cols_bad"}, col_bad, 0);
        check({tag, "_busy_cyc"}, busy_n, PRESS);
        check({tag, "_err_n"}, err_n, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done, n_col, n_busy, t, done_t;
        vec_t fresh;

        vecs[0]  = '{4'h5, 4'b0100, 3'b010, 1'b0, -1};
        vecs[1]  = '{4'hB, 4'b1000, 3'b000, 1'b0, -1};
        vecs[2]  = '{4'hB, 4'b0001, 3'b001, 1'b0, -1};
        vecs[3]  = '{4'h1, 4'b1000, 3'b100, 1'b0, -1};
        vecs[4]  = '{4'h9, 4'b1111, 3'b001, 1'b0, -1};
        vecs[5]  = '{4'hA, 4'b0101, 3'b100, 1'b0, -1};
        vecs[6]  = '{4'h0, 4'b0001, 3'b010, 1'b0, -1};
        vecs[7]  = '{4'h7, 4'b0010, 3'b100, 1'b0, -1};
        vecs[8]  = '{4'h3, 4'b0100, 3'b000, 1'b0, -1};
        vecs[9]  = '{4'hC, 4'b1111, 3'b000, 1'b1, -1};
        vecs[10] = '{4'h5, 4'b1100, 3'b010, 1'b0, 100};
        vecs[11] = '{4'hF, 4'b1111, 3'b000, 1'b1, -1};
        vecs[12] = '{4'h6, 4'b0100, 3'b001, 1'b0, -1};

        rst = 1'b1; kv = 1'b0; kc = 4'h0; {b, g, f, d} = 4'hF;
        kv2 = 1'b0; kc2 = 4'h0; {b2, g2, f2, d2} = 4'b0001;
        tick();
        tick();
        check("rst_cols", int'({c, a, e}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_nb_busy", int'(busy2), 0);
        rst = 1'b0;

        foreach (vecs[i]) press(vecs[i], $sformatf("v%0d", i));

        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) n_done++;
        end
        check("tail_done", n_done, 0);

        // Reset in the middle of a held press.
        {b, g, f, d} = 4'b0100;
        kc = 4'h5;
        kv = 1'b1;
        tick();
        kv = 1'b0;
        repeat (50) tick();
        check("rst_pre_hold_a", int'(a), 1);
        {b, g, f, d} = 4'hF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_cols", int'({c, a, e}), 0);
        check("rst_mid_busy", int'(busy), 0);
        n_done = 0; n_col = 0; n_busy = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (done) n_done++;
            if ({c, a, e} != 3'b000) n_col++;
            if (busy) n_busy++;
        end
        check("rst_mid_done", n_done, 0);
        check("rst_mid_col_n", n_col, 0);
        check("rst_mid_busy_n", n_busy, 0);
        fresh = '{4'h5, 4'b0100, 3'b010, 1'b0, -1};
        press(fresh, "post_rst");

        // No-bounce instance: clean HOLD_CYCLES pulse on A for key 0.
        kc2 = 4'h0;
        kv2 = 1'b1;
        tick();
        kv2 = 1'b0;
        sb_q.push_back(H_NB);
        n_col = 0; n_busy = 0; n_done = 0; done_t = -1;
        for (t = 0; t < 20; t++) begin
            if ({c2, a2, e2} != ((t < H_NB) ? 3'b010 : 3'b000)) n_col++;
            if (busy2) n_busy++;
            if (done2) begin
                n_done++;
                if (sb_q.size() == 0) check("nb_sb_empty", 1, 0);
                else check("nb_done_t", t, sb_q.pop_front());
            end
            tick();
        end
        check("nb_cols_bad", n_col, 0);
        check("nb_busy_cyc", n_busy, H_NB);
        check("nb_done_n", n_done, 1);
        check("sb_left", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable model of the 3-column × 4-row membrane keypad, used as the far end of the keypad driver's scan interface. It accepts a key-press request (key code plus hold time) and drives column lines A, C, E in response to the driver's row strobes B, G, F, D, including contact bounce on press and release. It is the stimulus source for self-checking driver benches and for on-board loopback tests without the physical keypad.

## Interface
Parameters:
- HOLD_CYCLES, 200: cycles the contact stays solidly closed between the two bounce phases; must be ≥1.
- BOUNCE_PERIOD, 3: cycles per bounce segment; must be ≥1.
- BOUNCE_TOGGLES, 4: segments per bounce phase; must be even; 0 disables bounce.

Ports:
- CLK  in  1  system clock; sole clock domain.
- RST  in  1  synchronous, active-high reset.
- B, G, F, D  in  1 each  row strobes from the driver (active-high); B = top row, G, F, D = rows 2, 3, 4.
- KEY_VALID  in  1  press request; sampled only while BUSY=0.
- KEY_CODE  in  4  key to press: 0x0–0x9 digits, 0xA = '*', 0xB = '#'.
- A, C, E  out  1 each  column returns: C = left, A = middle, E = right column.
- BUSY  out  1  high from request acceptance until the DONE edge.
- DONE  out  1  one-cycle pulse when the release completes.
- ERR  out  1  one-cycle pulse when a request carries code 0xC–0xF.

## Operation
- Key map (row, column): 1/2/3 = (B, C/A/E); 4/5/6 = (G, C/A/E); 7/8/9 = (F, C/A/E); '*'/0/'#' = (D, C/A/E).
- Registered state: FSM state, latched row index, latched column index, contact bit, segment counter, cycle counter.
- Column output = contact AND (latched row strobe) AND (column == latched column). This path is combinational, with zero latency from the row strobes, matching a passive keypad. All other column outputs are 0.
- FSM states:
  - IDLE → BOUNCE_IN on a valid request.
  - BOUNCE_IN → HOLD after BOUNCE_TOGGLES×BOUNCE_PERIOD cycles.
  - HOLD → BOUNCE_OUT after HOLD_CYCLES.
  - BOUNCE_OUT → IDLE after BOUNCE_TOGGLES×BOUNCE_PERIOD cycles, with DONE pulsed.
  - With BOUNCE_TOGGLES=0, the FSM goes IDLE → HOLD → IDLE.
- BOUNCE_IN: contact is closed during even-numbered segments and open during odd ones. It therefore starts closed and ends open.
- BOUNCE_OUT: contact is open during even-numbered segments and closed during odd ones. It ends closed, then opens in IDLE.
- Contact is 1 throughout HOLD and 0 in IDLE.
- Invalid code (0xC–0xF) with KEY_VALID in IDLE: ERR pulses, the FSM stays in IDLE, and the key latches are unchanged.
- KEY_VALID while BUSY=1 is ignored. There is no queueing.
- Multiple row strobes high at once: each column output still obeys the AND rule. No error is flagged.
- Counter widths: $clog2 of each parameter + 1. Counters reset to 0 on every state entry.

## Timing
- Reset values (next edge with RST=1): state IDLE, contact 0, counters 0. Outputs: A=C=E=0, BUSY=0, DONE=0, ERR=0.
- RST overrides everything, including a press in progress. The contact opens at that edge, and no DONE is produced.
- Request accepted at edge k → BUSY=1 and contact=1 after edge k.
- Contact changes at edges k+BOUNCE_PERIOD·n.
- DONE=1 for exactly the cycle after edge k+2·BOUNCE_TOGGLES·BOUNCE_PERIOD+HOLD_CYCLES. BUSY falls at that same edge, so BUSY and DONE never overlap.
- A new request may be accepted on the cycle DONE is high, i.e. back-to-back presses are allowed.
- ERR is asserted the cycle after the sampling edge. BUSY stays 0 throughout.

## Structure
- Package keypad_pkg:
  - Key-code constants KEY_STAR=4'hA, KEY_HASH=4'hB.
  - Row enum ROW_B/G/F/D and column enum COL_C/A/E.
  - FSM state enum.
  - Function key_to_rowcol(code) returning {valid, row, col}.
  - Reused by the driver's checker and scoreboard.
- One sub-module is natural: kp_bounce_gen. It generates the segment/parity counter and takes start, phase (in/out) and done.

## Test plan
- Defaults. KEY_CODE=5, pulse KEY_VALID at edge k, hold G=1 → A=1 exactly when contact=1. C=E=0. DONE at edge k+224. BUSY high for 224 cycles.
- KEY_CODE=0xB with only B strobed → A=C=E=0 for the whole press. Then strobe D → E follows the contact.
- KEY_CODE=0xC → ERR for one cycle, BUSY stays 0, columns stay 0.
- Second KEY_VALID (code 1) mid-HOLD → ignored. The press of 5 completes unchanged and DONE pulses once.
- RST during HOLD → columns 0 after the next edge, BUSY=0, no DONE. A fresh request is accepted afterwards.
- BOUNCE_TOGGLES=0, HOLD_CYCLES=10, KEY_CODE=0 with D held high → A is a clean 10-cycle pulse, DONE at edge k+10. The driver under test must report 0.
